// File: rtl/median_filter9.sv
// Streaming median-of-9 filter: gathers a 9-sample burst, bubble-sorts it in a fixed 45 cycles, emits the 5th largest.
// Optional output register stage enabled by defining MEDIAN_OUT_REG_EN.
module median_filter9 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DI,
    input  logic       DSI,
    output logic [7:0] DO,
    output logic       DSO
);

    typedef enum logic [1:0] {IDLE, LOAD, SORT, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [2:0] pass;
    logic [3:0] step;
    logic [7:0] win [9];
    logic [7:0] med_p0;
    logic       vld_p0;

    // Control: burst gathering, sort sequencing and the median result register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            pass   <= 3'd0;
            step   <= 4'd0;
            med_p0 <= 8'h00;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (DSI) begin
                        cnt   <= 4'd1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!DSI) begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end else if (cnt == 4'd8) begin
                        cnt   <= 4'd0;
                        pass  <= 3'd0;
                        step  <= 4'd0;
                        state <= SORT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SORT: begin
                    // Steps 0..7 compare neighbours; step 8 is a spare slot so each pass is 9 cycles.
                    if (step == 4'd8) begin
                        step <= 4'd0;
                        if (pass == 3'd4) begin
                            state <= DONE;
                        end else begin
                            pass <= pass + 3'd1;
                        end
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                DONE: begin
                    med_p0 <= win[4];
                    vld_p0 <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Window storage: loading and compare-exchange, no reset needed on the data path.
    // Each pass sinks the smallest remaining value, so after 5 passes slot 4 holds the 5th largest.
    always_ff @(posedge CLK) begin
        if ((state == IDLE || state == LOAD) && DSI) begin
            win[cnt] <= DI;
        end else if (state == SORT) begin
            for (int i = 0; i < 8; i++) begin
                if (step == 4'(i) && win[i] < win[i+1]) begin
                    win[i]   <= win[i+1];
                    win[i+1] <= win[i];
                end
            end
        end
    end

`ifdef MEDIAN_OUT_REG_EN
    logic [7:0] med_p1;
    logic       vld_p1;

    // Output stage: delays median and strobe together by one cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            med_p1 <= 8'h00;
            vld_p1 <= 1'b0;
        end else begin
            med_p1 <= med_p0;
            vld_p1 <= vld_p0;
        end
    end

    assign DO  = med_p1;
    assign DSO = vld_p1;
`else
    assign DO  = med_p0;
    assign DSO = vld_p0;
`endif

endmodule

// File: tb/tb_median_filter9.sv
// Scoreboard bench for median_filter9: stimulus pushes expected median and pulse cycle, a monitor checks every cycle.
module tb_median_filter9;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DI  = 8'h00;
    logic       DSI = 1'b0;
    logic [7:0] DO;
    logic       DSO;

`ifdef MEDIAN_OUT_REG_EN
    localparam int LAT = 47;
`else
    localparam int LAT = 46;
`endif

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    bit         mon_en = 1'b0;
    logic [7:0] held   = 8'h00;
    logic [7:0] exp_med [$];
    int         exp_cyc [$];
    logic [7:0] w [9];
    logic [7:0] mon_m;
    int         mon_c;

    median_filter9 dut (
        .CLK(CLK),
        .RST(RST),
        .DI (DI),
        .DSI(DSI),
        .DO (DO),
        .DSO(DSO)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Median by rank: the value with at most 4 strictly greater and at least 5 greater-or-equal.
    function automatic logic [7:0] ref_median(input logic [7:0] s [9]);
        for (int i = 0; i < 9; i++) begin
            int gt = 0;
            int ge = 0;
            for (int j = 0; j < 9; j++) begin
                if (s[j] >  s[i]) gt++;
                if (s[j] >= s[i]) ge++;
            end
            if (gt <= 4 && ge >= 5) return s[i];
        end
        return 8'h00;
    endfunction

    // Monitor: DSO must pulse exactly at the predicted cycle; DO must hold otherwise.
    always @(negedge CLK) begin
        if (mon_en && !RST) begin
            if (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
                mon_m = exp_med.pop_front();
                mon_c = exp_cyc.pop_front();
                check("dso_pulse", int'(DSO), 1);
                check("median", int'(DO), int'(mon_m));
                held = mon_m;
            end else begin
                check("dso_idle", int'(DSO), 0);
                check("do_hold", int'(DO), int'(held));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_window(input logic [7:0] s [9], input int n);
        for (int i = 0; i < n; i++) begin
            DI  = s[i];
            DSI = 1'b1;
            @(posedge CLK);
            #1;
        end
        DSI = 1'b0;
        DI  = 8'h00;
        if (n == 9) begin
            exp_med.push_back(ref_median(s));
            exp_cyc.push_back(cyc + LAT);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_med.size() > 0; k++) idle(1);
        check("drain", exp_med.size(), 0);
        idle(2);
    endtask

    initial begin
        RST = 1'b1;
        idle(3);
        check("reset_do", int'(DO), 0);
        check("reset_dso", int'(DSO), 0);
        RST = 1'b0;
        mon_en = 1'b1;
        idle(5);

        w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send_window(w, 9);
        drain();
        w = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        send_window(w, 9);
        drain();
        w = '{8'd0, 8'd255, 8'd255, 8'd0, 8'd128, 8'd128, 8'd128, 8'd7, 8'd200};
        send_window(w, 9);
        drain();
        w = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        send_window(w, 9);
        drain();
        w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
        send_window(w, 9);
        drain();

        // Partial burst must vanish without a pulse.
        w = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        send_window(w, 4);
        idle(3);
        send_window(w, 9);
        drain();

        // Back-to-back with DSI held high through SORT and DONE.
        w = '{8'd33, 8'd12, 8'd250, 8'd99, 8'd1, 8'd180, 8'd64, 8'd64, 8'd3};
        send_window(w, 9);
        DSI = 1'b1;
        repeat (46) begin
            DI = 8'($urandom);
            idle(1);
        end
        DSI = 1'b0;
        idle(1);
        w = '{8'd77, 8'd200, 8'd5, 8'd77, 8'd140, 8'd90, 8'd20, 8'd77, 8'd31};
        send_window(w, 9);
        drain();

        // Asynchronous reset mid-sort clears outputs at once and kills the window.
        w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send_window(w, 9);
        idle(10);
        #2;
        RST = 1'b1;
        #1;
        check("async_reset_do", int'(DO), 0);
        check("async_reset_dso", int'(DSO), 0);
        exp_med.delete();
        exp_cyc.delete();
        held = 8'h00;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(60);

        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 9; i++) w[i] = 8'($urandom);
            send_window(w, 9);
            repeat (46) begin
                DSI = 1'($urandom_range(0, 1));
                DI  = 8'($urandom);
                idle(1);
            end
            DSI = 1'b0;
            idle(1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
